// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between the fetch (F) and data (D) paths of the
// multicycle CPU: fixed D-over-F priority, F starvation guard, fixed read latency.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              f_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              win_d_q, win_d_d;
    logic              grant_f;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            lat_q       <= '0;
            starve_q    <= '0;
            win_d_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            win_d_q     <= win_d_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        win_d_d     = win_d_q;
        grant_f     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    // F overrides D only once D has won STARVE_MAX times in a row
                    grant_f = f_req && (!d_req || starve_q == 4'(STARVE_MAX));
                    state_d = ACCESS;
                    if (grant_f) begin
                        mem_addr_d  = f_addr;
                        mem_wr_d    = 1'b0;
                        mem_wdata_d = '0;
                        win_d_d     = 1'b0;
                        starve_d    = '0;
                        lat_d       = 3'(READ_LAT - 1);
                    end else begin
                        mem_addr_d  = d_addr;
                        mem_wr_d    = d_we;
                        mem_wdata_d = d_wdata;
                        win_d_d     = 1'b1;
                        starve_d    = f_req ? starve_q + 4'd1 : 4'd0;
                        lat_d       = d_we ? 3'd0 : 3'(READ_LAT - 1);
                    end
                end
            end
            ACCESS: begin
                if (lat_q == 3'd0) begin
                    state_d  = DONE;
                    mem_wr_d = 1'b0;
                    if (!mem_wr_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign f_done    = (state_q == DONE) && !win_d_q;
    assign d_done    = (state_q == DONE) && win_d_q;
    assign busy      = (state_q != IDLE);
    assign state_out = state_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level schedule predicted from the arbitration
// and latency rules, checked cycle by cycle against a latency-accurate memory model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int SM = 3;

    logic          clock, reset;
    logic          f_req, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, rdata, mem_wdata, mem_rdata;
    logic          f_done, d_done, mem_wr, busy;
    logic [1:0]    state_out;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .STARVE_MAX(SM)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .f_done(f_done), .d_done(d_done), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_out(state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 16) return 32'h8C220004;
        return 32'hA5000000 ^ (i * 32'h00010203);
    endfunction

    // Memory: word index addr[9:2]; read data appears RL cycles after the address.
    logic [31:0] mem [0:255];
    logic [31:0] pipe [0:6];
    logic        mem_init;
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_wr) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        pipe[0] <= mem[mem_addr[9:2]];
        for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = (RL == 1) ? mem[mem_addr[9:2]] : pipe[(RL >= 2) ? RL - 2 : 0];

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [0:255];
    int          starve;
    logic [31:0] exp_rdata;
    logic        dq_we   [0:7];
    logic [31:0] dq_addr [0:7];
    logic [31:0] dq_wd   [0:7];
    logic [31:0] f_a;
    bit          s_isd  [0:8];
    int          s_g    [0:8];
    int          s_t    [0:8];
    logic [31:0] s_addr [0:8];
    logic        s_we   [0:8];
    logic [31:0] s_wd   [0:8];
    logic [31:0] s_rd   [0:8];
    int          obs_d_before_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; that cycle is cycle 0 of the batch.
    task automatic run(input bit f_on, input int nd);
        int n, dn, g, k, dnext;
        bit fpend, f_seen, pick_d;
        logic [31:0] rd, rd0;
        n = 0; fpend = f_on; dn = 0; g = 0; rd = exp_rdata; rd0 = exp_rdata;
        while (fpend || dn < nd) begin
            if (fpend && dn < nd) pick_d = (starve != SM);
            else pick_d = (dn < nd);
            if (pick_d) starve = fpend ? starve + 1 : 0;
            else starve = 0;
            s_isd[n] = pick_d;
            s_g[n] = g;
            if (pick_d) begin
                s_addr[n] = dq_addr[dn]; s_we[n] = dq_we[dn]; s_wd[n] = dq_wd[dn]; dn++;
            end else begin
                s_addr[n] = f_a; s_we[n] = 1'b0; s_wd[n] = '0; fpend = 0;
            end
            if (s_we[n]) begin
                ref_mem[s_addr[n][9:2]] = s_wd[n];
                s_t[n] = g + 2;
            end else begin
                rd = ref_mem[s_addr[n][9:2]];
                s_t[n] = g + RL + 1;
            end
            s_rd[n] = rd;
            g = s_t[n] + 1;
            n++;
        end

        f_addr = f_a; f_req = f_on; d_req = (nd > 0);
        d_we = dq_we[0]; d_addr = dq_addr[0]; d_wdata = dq_wd[0];
        k = 0; dnext = 0; f_seen = 0; obs_d_before_f = 0;
        for (int c = 1; c <= g; c++) begin
            @(negedge clock);
            while (k < n && c > s_t[k]) k++;
            check("done_overlap", {31'b0, f_done & d_done}, 32'd0);
            if (d_done && !f_seen) obs_d_before_f++;
            if (f_done) f_seen = 1;
            if (k == n || c == s_g[k]) begin
                check("idle_state", {30'b0, state_out}, 32'd0);
                check("idle_busy", {31'b0, busy}, 32'd0);
                check("idle_done", {30'b0, f_done, d_done}, 32'd0);
            end else if (c < s_t[k]) begin
                check("acc_state", {30'b0, state_out}, 32'd1);
                check("acc_busy", {31'b0, busy}, 32'd1);
                check("acc_addr", mem_addr, s_addr[k]);
                check("acc_wr", {31'b0, mem_wr}, {31'b0, s_we[k]});
                if (s_we[k]) check("acc_wdata", mem_wdata, s_wd[k]);
                check("acc_rdata_hold", rdata, (k == 0) ? rd0 : s_rd[k-1]);
                if (c == s_g[k] + 1) begin
                    if (s_isd[k]) begin
                        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
                    end else begin
                        f_addr = $urandom;
                    end
                end
            end else begin
                check("done_state", {30'b0, state_out}, 32'd2);
                check("done_busy", {31'b0, busy}, 32'd1);
                check("done_f", {31'b0, f_done}, {31'b0, !s_isd[k]});
                check("done_d", {31'b0, d_done}, {31'b0, s_isd[k]});
                check("done_wr", {31'b0, mem_wr}, 32'd0);
                check("done_addr", mem_addr, s_addr[k]);
                check("done_rdata", rdata, s_rd[k]);
                if (s_isd[k]) begin
                    dnext++;
                    if (dnext < nd) begin
                        d_we = dq_we[dnext]; d_addr = dq_addr[dnext]; d_wdata = dq_wd[dnext];
                    end else begin
                        d_req = 1'b0;
                    end
                end else begin
                    f_req = 1'b0;
                end
            end
        end
        exp_rdata = s_rd[n-1];
    endtask

    task automatic fill_rand(input int nd);
        for (int i = 0; i < nd; i++) begin
            dq_we[i] = 1'($urandom);
            dq_addr[i] = {22'h0, 8'($urandom), 2'b00};
            dq_wd[i] = $urandom;
        end
    endtask

    initial begin
        reset = 1'b0; mem_init = 1'b1;
        f_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
        f_a = 32'h40; f_addr = f_a; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        starve = 0; exp_rdata = '0;
        repeat (3) @(negedge clock);
        mem_init = 1'b0;
        check("rst_state", {30'b0, state_out}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {30'b0, f_done, d_done}, 32'd0);
        check("rst_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b1;

        run(1, 0);
        check("fetch_rdata", rdata, 32'h8C220004);

        dq_we[0] = 1'b1; dq_addr[0] = 32'h100; dq_wd[0] = 32'hDEADBEEF;
        run(0, 1);
        check("store_rdata_kept", rdata, 32'h8C220004);
        check("store_mem", mem[64], 32'hDEADBEEF);

        dq_we[0] = 1'b0; dq_addr[0] = 32'h100; f_a = 32'h80;
        run(1, 1);
        check("simul_d_first", 32'(obs_d_before_f), 32'd1);

        f_req = 1'b1; f_addr = 32'h40;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_state", {30'b0, state_out}, 32'd0);
        check("mid_rst_fdone", {31'b0, f_done}, 32'd0);
        @(negedge clock);
        check("mid_rst_fdone2", {31'b0, f_done}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        starve = 0; exp_rdata = '0;
        reset = 1'b1;
        f_a = 32'h40;
        run(1, 0);
        check("reissue_rdata", rdata, 32'h8C220004);

        fill_rand(5);
        for (int i = 0; i < 5; i++) dq_we[i] = 1'b0;
        f_a = 32'h3C;
        run(1, 5);
        check("starve_d_before_f", 32'(obs_d_before_f), 32'd3);
        fill_rand(1);
        run(1, 1);
        check("starve_cleared", 32'(obs_d_before_f), 32'd1);

        for (int it = 0; it < 30; it++) begin
            bit fo;
            int nd;
            fo = 1'($urandom_range(0, 1));
            nd = $urandom_range(0, 4);
            if (!fo && nd == 0) nd = 1;
            fill_rand(nd);
            f_a = {22'h0, 8'($urandom), 2'b00};
            run(fo, nd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
